// File: rtl/crossing_pkg.sv
// Shared types and constants for the level-crossing scheduler.
package crossing_pkg;

    typedef enum logic [2:0] {
        ROAD_GO      = 3'd0,
        ROAD_WARN    = 3'd1,
        ROAD_STOP    = 3'd2,
        TRACK_GO     = 3'd3,
        TRACK_SWITCH = 3'd4,
        ROAD_RECOVER = 3'd5
    } state_t;

    // Road lamp encoding, packed as {red, yellow, green}.
    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    localparam logic [1:0] GRANT_NONE = 2'b00;

    // One-hot grant vector for a selected track.
    function automatic logic [1:0] onehot_sel(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

    // Round-robin pick: a lone requester wins; on a tie the track that was
    // not served last wins.
    function automatic logic arbitrate(input logic [1:0] req, input logic last);
        logic pick;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            default: pick = ~last;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Programmable tick generator: one-cycle tick every 2^(PRE_W+divider) clocks.
// A restart clears the count so a new state always begins a full period.
module tick_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       restart,
    input  logic [1:0] divider,
    output logic       tick
);

    localparam int CNT_W = PRE_W + 3;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       div_q;
    logic [CNT_W-1:0] limit;

    // Terminal count for the latched divider: all-ones mask of PRE_W+div bits.
    always_comb begin
        limit = {CNT_W{1'b1}} >> (2'd3 - div_q);
        tick  = (cnt == limit);
    end

    // Count up; the divider is re-sampled only at restart or wrap.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt   <= '0;
            div_q <= 2'd0;
        end else if (restart || tick) begin
            cnt   <= '0;
            div_q <= divider;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/crossing_ctrl.sv
// Level-crossing scheduler: sequences road lamps and barrier, and grants the
// crossing to one of two tracks at a time, round-robin.
//
//   state        | meaning
//   -------------+--------------------------------------------------
//   ROAD_GO      | road green, barrier up, waiting for a train
//   ROAD_WARN    | road yellow for YEL_TICKS, sequence committed
//   ROAD_STOP    | road red, barrier down, clearance before grant
//   TRACK_GO     | one track granted until done or withdrawn
//   TRACK_SWITCH | grant dropped, clearance before serving the other
//   ROAD_RECOVER | barrier up, road still red, then back to green
module crossing_ctrl
    import crossing_pkg::*;
#(
    parameter int PRE_W     = 4,
    parameter int YEL_TICKS = 4,
    parameter int CLR_TICKS = 2
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] divider,
    input  logic [1:0] req,
    input  logic [1:0] done,
    output logic       red,
    output logic       yellow,
    output logic       green,
    output logic       barrier,
    output logic [1:0] grant
);

    localparam int TMR_W = 4;
    localparam logic [TMR_W-1:0] YEL_LOAD = TMR_W'(YEL_TICKS - 1);
    localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_TICKS - 1);

    state_t           state, state_nx;
    logic             sel, sel_nx;
    logic             last;
    logic [TMR_W-1:0] tmr, tmr_load;
    logic             tick;
    logic             restart;
    logic             tmr_exp;
    logic             other;

    tick_prescaler #(.PRE_W(PRE_W)) u_presc (
        .clk     (clk),
        .clr_n   (clr_n),
        .restart (restart),
        .divider (divider),
        .tick    (tick)
    );

    // Timed states expire on the tick that finds the down-counter at zero.
    always_comb begin
        other   = ~sel;
        tmr_exp = tick && (tmr == '0);
    end

    // Next state, next selected track and prescaler restart on any change.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        case (state)
            ROAD_GO: begin
                if (req != 2'b00) state_nx = ROAD_WARN;
            end
            ROAD_WARN: begin
                if (tmr_exp) state_nx = ROAD_STOP;
            end
            ROAD_STOP: begin
                if (tmr_exp) begin
                    if (req != 2'b00) begin
                        state_nx = TRACK_GO;
                        sel_nx   = arbitrate(req, last);
                    end else begin
                        state_nx = ROAD_RECOVER;
                    end
                end
            end
            TRACK_GO: begin
                if (done[sel] || !req[sel]) begin
                    state_nx = req[other] ? TRACK_SWITCH : ROAD_RECOVER;
                end
            end
            TRACK_SWITCH: begin
                if (tmr_exp) begin
                    if (req[other]) begin
                        state_nx = TRACK_GO;
                        sel_nx   = other;
                    end else begin
                        state_nx = ROAD_RECOVER;
                    end
                end
            end
            ROAD_RECOVER: begin
                if (tmr_exp) state_nx = ROAD_GO;
            end
            default: state_nx = ROAD_GO;
        endcase
        restart = (state_nx != state);
    end

    // Tick budget loaded on entry to each state.
    always_comb begin
        case (state_nx)
            ROAD_WARN:    tmr_load = YEL_LOAD;
            ROAD_STOP,
            TRACK_SWITCH,
            ROAD_RECOVER: tmr_load = CLR_LOAD;
            default:      tmr_load = '0;
        endcase
    end

    // State, arbitration memory and tick down-counter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= ROAD_GO;
            sel   <= 1'b0;
            last  <= 1'b1;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            if (restart && (state_nx == TRACK_GO)) last <= sel_nx;
            if (restart)                           tmr  <= tmr_load;
            else if (tick && (tmr != '0))          tmr  <= tmr - 1'b1;
        end
    end

    // Moore output decode of the registered state.
    always_comb begin
        {red, yellow, green} = LIGHT_R;
        barrier              = 1'b1;
        grant                = GRANT_NONE;
        case (state)
            ROAD_GO: begin
                {red, yellow, green} = LIGHT_G;
                barrier              = 1'b0;
            end
            ROAD_WARN: begin
                {red, yellow, green} = LIGHT_Y;
                barrier              = 1'b0;
            end
            TRACK_GO:     grant   = onehot_sel(sel);
            ROAD_RECOVER: barrier = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_crossing_ctrl.sv
// Directed bench for crossing_ctrl: lamp/barrier/grant sequencing, state
// durations at several tick speeds, arbitration and asynchronous reset.
module tb_crossing_ctrl;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [1:0] divider;
    logic [1:0] req;
    logic [1:0] done;
    logic       red, yellow, green, barrier;
    logic [1:0] grant;
    logic [5:0] outs;
    logic [5:0] prev;

    int n_cmp = 0;
    int n_err = 0;

    // {red, yellow, green, barrier, grant[1:0]}
    localparam logic [5:0] O_GO   = 6'b001_0_00;
    localparam logic [5:0] O_WARN = 6'b010_0_00;
    localparam logic [5:0] O_STOP = 6'b100_1_00;
    localparam logic [5:0] O_TG0  = 6'b100_1_01;
    localparam logic [5:0] O_TG1  = 6'b100_1_10;
    localparam logic [5:0] O_REC  = 6'b100_0_00;

    always #5 clk = ~clk;

    assign outs = {red, yellow, green, barrier, grant};

    crossing_ctrl #(.PRE_W(4), .YEL_TICKS(4), .CLR_TICKS(2)) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .divider (divider),
        .req     (req),
        .done    (done),
        .red     (red),
        .yellow  (yellow),
        .green   (green),
        .barrier (barrier),
        .grant   (grant)
    );

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one clock, sample 1 ns after the edge and check invariants.
    task automatic cycle();
        logic bad_dir;
        @(posedge clk);
        #1;
        chk("inv_one_lamp", {5'b0, $onehot({red, yellow, green})}, 6'd1);
        chk("inv_grant_safe", {5'b0, (grant == 2'b00) || (red && barrier)}, 6'd1);
        chk("inv_grant_onehot", {5'b0, grant != 2'b11}, 6'd1);
        bad_dir = (prev[3] && (grant != 2'b00)) || ((prev[1:0] != 2'b00) && green);
        chk("inv_no_direct", {5'b0, bad_dir}, 6'd0);
        prev = outs;
    endtask

    task automatic hold(input string tag, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            cycle();
            chk(tag, outs, exp);
        end
    endtask

    task automatic pulse(input logic [1:0] d, input logic [1:0] r,
                         input string tag, input logic [5:0] exp);
        done = d;
        req  = r;
        cycle();
        done = 2'b00;
        chk(tag, outs, exp);
    endtask

    initial begin
        clr_n   = 1'b0;
        divider = 2'd0;
        req     = 2'b00;
        done    = 2'b00;
        #1;
        chk("reset_outs", outs, O_GO);
        #11;
        clr_n = 1'b1;
        prev  = outs;
        hold("idle", 10, O_GO);

        // Single train on track 0 at the fastest speed (16-cycle tick).
        req = 2'b01;
        hold("s1_warn", 64, O_WARN);
        hold("s1_stop", 32, O_STOP);
        hold("s1_tg0", 5, O_TG0);
        pulse(2'b01, 2'b00, "s1_done0", O_REC);
        hold("s1_rec", 31, O_REC);
        hold("s1_go", 4, O_GO);

        // Tie after track 0 was served: track 1 first, then switch, done
        // filtering, done+req same cycle, and withdrawals.
        req = 2'b11;
        hold("s2_warn", 64, O_WARN);
        hold("s2_stop", 32, O_STOP);
        hold("s2_tg1", 4, O_TG1);
        pulse(2'b10, 2'b01, "s2_done1", O_STOP);
        hold("s2_switch", 31, O_STOP);
        hold("s2_tg0", 4, O_TG0);
        pulse(2'b10, 2'b01, "s2_done1_ignored", O_TG0);
        hold("s2_tg0_hold", 3, O_TG0);
        pulse(2'b01, 2'b11, "s2_done0_req1", O_STOP);
        hold("s2_switch2", 31, O_STOP);
        hold("s2_tg1b", 3, O_TG1);
        req = 2'b01;
        hold("s2_wd1_switch", 32, O_STOP);
        hold("s2_tg0b", 3, O_TG0);
        req = 2'b00;
        hold("s2_wd0_rec", 32, O_REC);
        hold("s2_go", 4, O_GO);

        // Tie again gives track 1; reset mid-grant restores track 0 priority.
        req = 2'b11;
        hold("s3_warn", 64, O_WARN);
        hold("s3_stop", 32, O_STOP);
        hold("s3_tg1", 3, O_TG1);
        clr_n = 1'b0;
        #1;
        chk("s3_async_rst", outs, O_GO);
        #2;
        clr_n = 1'b1;
        prev  = outs;
        hold("s3_warn_rst", 64, O_WARN);
        hold("s3_stop_rst", 32, O_STOP);
        hold("s3_tg0_rst", 3, O_TG0);
        pulse(2'b01, 2'b00, "s3_done0", O_REC);
        hold("s3_rec", 31, O_REC);
        hold("s3_go", 4, O_GO);

        // Request dropped during yellow: sequence runs through with no grant.
        req = 2'b01;
        hold("s4_warn_a", 10, O_WARN);
        req = 2'b00;
        hold("s4_warn_b", 54, O_WARN);
        hold("s4_stop", 32, O_STOP);
        hold("s4_rec", 32, O_REC);
        hold("s4_go", 4, O_GO);

        // Slowest speed (128-cycle tick) on track 1.
        divider = 2'd3;
        req     = 2'b10;
        hold("s5_warn", 512, O_WARN);
        hold("s5_stop", 256, O_STOP);
        hold("s5_tg1", 3, O_TG1);
        pulse(2'b10, 2'b00, "s5_done1", O_REC);
        hold("s5_rec", 255, O_REC);
        hold("s5_go", 4, O_GO);

        // Divider changed mid-period: one 128-cycle tick, then three of 16.
        req = 2'b10;
        hold("s6_warn_a", 50, O_WARN);
        divider = 2'd0;
        hold("s6_warn_b", 126, O_WARN);
        hold("s6_stop", 32, O_STOP);
        hold("s6_tg1", 3, O_TG1);
        pulse(2'b10, 2'b00, "s6_done1", O_REC);
        hold("s6_rec", 31, O_REC);
        hold("s6_go", 4, O_GO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
